// File: rtl/mac_pe_pkg.sv
//----------------------------------------------------------------------------
// Module  : mac_pe_pkg
// Brief   : Shared widths, weight field layout and saturating add for mac_pe_dbuf.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package mac_pe_pkg;

   localparam int DEF_A_W   = 4;
   localparam int DEF_M_W   = 4;
   localparam int DEF_E_W   = 4;
   localparam int DEF_ACC_W = 32;

   // Wide enough to hold any ACC_W+1 bit sum without wrapping.
   localparam int SAT_CALC_W = 64;

   localparam int W_MANT_LSB = 0;

   function automatic int w_exp_lsb(input int m_w);
      return m_w;
   endfunction

   typedef struct packed {
      logic [DEF_E_W-1:0] exp;
      logic [DEF_M_W-1:0] mant;
   } weight_t;

   localparam logic [DEF_ACC_W-1:0] SAT_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
   localparam logic [DEF_ACC_W-1:0] SAT_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

   typedef struct packed {
      logic                  sat;
      logic [SAT_CALC_W-1:0] sum;
   } sat_res_t;

   // Operands must already be sign-extended from acc_w bits.
   function automatic sat_res_t sat_add(
      input logic signed [SAT_CALC_W-1:0] a,
      input logic signed [SAT_CALC_W-1:0] b,
      input int                           acc_w,
      input logic                         sat_en
   );
      logic signed [SAT_CALC_W-1:0] r;
      logic signed [SAT_CALC_W-1:0] hi;
      logic signed [SAT_CALC_W-1:0] lo;
      sat_res_t                     res;
      r       = a + b;
      hi      = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
      lo      = -hi - 64'sd1;
      res.sat = 1'b0;
      res.sum = r;
      if (sat_en && (r > hi)) begin
         res.sat = 1'b1;
         res.sum = hi;
      end else if (sat_en && (r < lo)) begin
         res.sat = 1'b1;
         res.sum = lo;
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mac_pe_dbuf.sv
//----------------------------------------------------------------------------
// Module  : mac_pe_dbuf
// Brief   : Weight-stationary systolic PE, double-buffered shift-scaled weight,
//           valid-qualified 2-stage MAC with optional saturation.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module mac_pe_dbuf
   import mac_pe_pkg::*;
#(
   parameter int A_W    = DEF_A_W,
   parameter int M_W    = DEF_M_W,
   parameter int E_W    = DEF_E_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter bit SAT_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [A_W-1:0]     in_a,
   input  logic               in_a_valid,
   output logic [A_W-1:0]     out_a,
   output logic               out_a_valid,
   input  logic [ACC_W-1:0]   in_sum,
   output logic [ACC_W-1:0]   out_sum,
   output logic               out_sum_valid,
   output logic               out_sat,
   input  logic [M_W+E_W-1:0] w_in,
   output logic [M_W+E_W-1:0] w_out,
   input  logic               w_load_en,
   input  logic               w_swap
);

   localparam int W_W     = M_W + E_W;
   localparam int P_W     = A_W + M_W;
   localparam int EXP_LSB = w_exp_lsb(M_W);

   generate
      if (A_W + M_W + (2**E_W) - 1 > ACC_W) begin : g_width_err
         $error("mac_pe_dbuf: ACC_W too small for shifted product");
      end
      if (ACC_W >= SAT_CALC_W) begin : g_acc_err
         $error("mac_pe_dbuf: ACC_W exceeds saturating adder width");
      end
   endgenerate

   logic [W_W-1:0]          shadow;
   logic [W_W-1:0]          active;
   logic signed [P_W-1:0]   p1;
   logic [E_W-1:0]          e1;
   logic signed [ACC_W-1:0] s1;
   logic                    v1;

   logic signed [A_W-1:0]   a_s;
   logic signed [M_W-1:0]   mant_s;
   logic signed [P_W-1:0]   prod;
   logic signed [ACC_W-1:0] shifted;
   sat_res_t                res;
   logic [SAT_CALC_W-ACC_W-1:0] res_hi_unused;
   logic [ACC_W-1:0]        res_sum;

   assign a_s    = $signed(in_a);
   assign mant_s = $signed(active[W_MANT_LSB +: M_W]);
   // Full-width signed product: the extreme corner (-2^(A_W-1))*(-2^(M_W-1)) fits.
   assign prod   = P_W'(a_s) * P_W'(mant_s);

   assign shifted = ACC_W'(p1) <<< e1;
   assign res     = sat_add(SAT_CALC_W'(s1), SAT_CALC_W'(shifted), ACC_W, SAT_EN);
   assign {res_hi_unused, res_sum} = res.sum;

   assign w_out = shadow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow        <= '0;
         active        <= '0;
         p1            <= '0;
         e1            <= '0;
         s1            <= '0;
         v1            <= 1'b0;
         out_a         <= '0;
         out_a_valid   <= 1'b0;
         out_sum       <= '0;
         out_sum_valid <= 1'b0;
         out_sat       <= 1'b0;
      end else begin
         out_a       <= in_a;
         out_a_valid <= in_a_valid;

         // Swap reads the pre-edge shadow, so load and swap may coincide.
         if (w_load_en) shadow <= w_in;
         if (w_swap)    active <= shadow;

         p1 <= prod;
         e1 <= active[EXP_LSB +: E_W];
         s1 <= in_sum;
         v1 <= in_a_valid;

         if (v1) begin
            out_sum       <= res_sum;
            out_sat       <= res.sat;
            out_sum_valid <= 1'b1;
         end else begin
            out_sat       <= 1'b0;
            out_sum_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire
